// File: rtl/exc_commit_pkg.sv
// rtl/exc_commit_pkg.sv - shared CPU constants, FSM state enum and event-select types for exception commit
package exc_commit_pkg;

    // Exception codes seen by the commit stage
    localparam logic [4:0]  EXC_INT  = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;
    localparam logic [4:0]  EXC_TR   = 5'd13;

    // Exception handler entry point (boot-time vector)
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_CP0WR = 2'd2,
        ST_REDIR = 2'd3
    } exc_state_t;

    // Winning event of the per-way priority selection
    typedef struct packed {
        logic       valid;
        logic       way;
        logic [4:0] code;
        logic       eret;
    } exc_sel_t;

    // Address-error exceptions are the only ones that also load BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_select.sv
// rtl/exc_select.sv - combinational per-way exception/eret priority selection (trap events under EXC_TRAP_EN)
module exc_select
    import exc_commit_pkg::*;
(
    input  logic [1:0]      valid_i,
    input  logic [1:0]      has_exc_i,
    input  logic [1:0][4:0] exc_code_i,
    input  logic [1:0]      eret_i,
    input  logic [4:0]      trap_exc_code_i,
    input  logic [1:0]      trap_way_i,
    input  logic            int_pending_i,
    output exc_sel_t        sel_o
);

    logic [1:0]      trap_hit;
    logic [1:0]      way_evt;
    logic [1:0][4:0] way_code;
    logic [1:0]      way_eret;

`ifdef EXC_TRAP_EN
    // A trap only counts when the trap unit reports the Tr code for that way
    assign trap_hit = trap_way_i & {2{trap_exc_code_i == EXC_TR}};
`else
    // Trap unit present on the interface but never raises an event
    logic unused_trap;
    assign unused_trap = ^{trap_exc_code_i, trap_way_i};
    assign trap_hit    = 2'b00;
`endif

    // Per-way event and code: interrupt (way0 only) > pipeline exc > trap > eret
    always_comb begin
        way_evt  = '0;
        way_code = '0;
        way_eret = '0;
        for (int w = 0; w < 2; w++) begin
            if (w == 0 && int_pending_i && valid_i[0]) begin
                way_evt[w]  = 1'b1;
                way_code[w] = EXC_INT;
            end else if (valid_i[w] && has_exc_i[w]) begin
                way_evt[w]  = 1'b1;
                way_code[w] = exc_code_i[w];
            end else if (valid_i[w] && trap_hit[w]) begin
                way_evt[w]  = 1'b1;
                way_code[w] = EXC_TR;
            end else if (valid_i[w] && eret_i[w]) begin
                way_evt[w]  = 1'b1;
                way_eret[w] = 1'b1;
            end
        end
    end

    // Older way wins; the younger way's event is dropped and flushed later
    always_comb begin
        sel_o = '0;
        if (way_evt[0]) begin
            sel_o.valid = 1'b1;
            sel_o.way   = 1'b0;
            sel_o.code  = way_code[0];
            sel_o.eret  = way_eret[0];
        end else if (way_evt[1]) begin
            sel_o.valid = 1'b1;
            sel_o.way   = 1'b1;
            sel_o.code  = way_code[1];
            sel_o.eret  = way_eret[1];
        end
    end

endmodule

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - exception/eret commit FSM: flush, CP0 write, fetch redirect (optional EXC_TRAP_EN trap events)
module exc_commit
    import exc_commit_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       valid_i,
    input  logic [1:0][4:0]  exc_code_i,
    input  logic [1:0]       has_exc_i,
    input  logic [1:0][31:0] pc_i,
    input  logic [1:0]       bd_i,
    input  logic [1:0][31:0] badvaddr_i,
    input  logic [1:0]       eret_i,
    input  logic [4:0]       trap_exc_code_i,
    input  logic [1:0]       trap_way_i,
    input  logic             int_pending_i,
    input  logic [31:0]      epc_i,
    output logic [1:0]       commit_mask_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             cp0_we_o,
    output logic [4:0]       cp0_exc_code_o,
    output logic [31:0]      cp0_epc_o,
    output logic             cp0_bd_o,
    output logic             cp0_badv_we_o,
    output logic [31:0]      cp0_badvaddr_o,
    output logic             cp0_eret_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o
);

    exc_state_t  state_q;
    exc_sel_t    sel;

    // Event captured in IDLE
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic        bd_q;
    logic [31:0] badv_q;
    logic        eret_q;

    // Registered outputs
    logic        flush_q;
    logic        cp0_we_q;
    logic [4:0]  cp0_code_q;
    logic [31:0] cp0_epc_q;
    logic        cp0_bd_q;
    logic        cp0_badv_we_q;
    logic [31:0] cp0_badv_q;
    logic        cp0_eret_q;
    logic        redir_valid_q;

    logic [31:0] epc_d;
    logic        badv_we_d;
    logic [1:0]  commit_mask_d;

    exc_select u_select (
        .valid_i         (valid_i),
        .has_exc_i       (has_exc_i),
        .exc_code_i      (exc_code_i),
        .eret_i          (eret_i),
        .trap_exc_code_i (trap_exc_code_i),
        .trap_way_i      (trap_way_i),
        .int_pending_i   (int_pending_i),
        .sel_o           (sel)
    );

    // Delay-slot instructions report the branch PC (wraps modulo 2^32)
    assign epc_d     = bd_q ? (pc_q - 32'd4) : pc_q;
    assign badv_we_d = is_addr_exc(code_q);

    // Ways allowed to retire: everything older than the selected event
    always_comb begin
        commit_mask_d = 2'b00;
        if (resetn && state_q == ST_IDLE) begin
            if (!sel.valid) begin
                commit_mask_d = valid_i;
            end else if (sel.way) begin
                commit_mask_d = 2'b01 & valid_i;
            end
        end
    end

    // Commit FSM with event latches and registered pulse/data outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            code_q        <= '0;
            pc_q          <= '0;
            bd_q          <= 1'b0;
            badv_q        <= '0;
            eret_q        <= 1'b0;
            flush_q       <= 1'b0;
            cp0_we_q      <= 1'b0;
            cp0_code_q    <= '0;
            cp0_epc_q     <= '0;
            cp0_bd_q      <= 1'b0;
            cp0_badv_we_q <= 1'b0;
            cp0_badv_q    <= '0;
            cp0_eret_q    <= 1'b0;
            redir_valid_q <= 1'b0;
        end else begin
            flush_q       <= 1'b0;
            cp0_we_q      <= 1'b0;
            cp0_code_q    <= '0;
            cp0_epc_q     <= '0;
            cp0_bd_q      <= 1'b0;
            cp0_badv_we_q <= 1'b0;
            cp0_badv_q    <= '0;
            cp0_eret_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel.valid) begin
                        code_q  <= sel.code;
                        pc_q    <= pc_i[sel.way];
                        bd_q    <= bd_i[sel.way];
                        badv_q  <= badvaddr_i[sel.way];
                        eret_q  <= sel.eret;
                        flush_q <= 1'b1;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_CP0WR;
                    if (eret_q) begin
                        cp0_eret_q <= 1'b1;
                    end else begin
                        cp0_we_q      <= 1'b1;
                        cp0_code_q    <= code_q;
                        cp0_epc_q     <= epc_d;
                        cp0_bd_q      <= bd_q;
                        cp0_badv_we_q <= badv_we_d;
                        cp0_badv_q    <= badv_we_d ? badv_q : 32'd0;
                    end
                end
                ST_CP0WR: begin
                    state_q       <= ST_REDIR;
                    redir_valid_q <= 1'b1;
                end
                ST_REDIR: begin
                    state_q <= ST_IDLE;
                    code_q  <= '0;
                    pc_q    <= '0;
                    bd_q    <= 1'b0;
                    badv_q  <= '0;
                    eret_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign commit_mask_o    = commit_mask_d;
    assign stall_o          = (state_q != ST_IDLE);
    assign flush_o          = flush_q;
    assign cp0_we_o         = cp0_we_q;
    assign cp0_exc_code_o   = cp0_code_q;
    assign cp0_epc_o        = cp0_epc_q;
    assign cp0_bd_o         = cp0_bd_q;
    assign cp0_badv_we_o    = cp0_badv_we_q;
    assign cp0_badvaddr_o   = cp0_badv_q;
    assign cp0_eret_o       = cp0_eret_q;
    assign redirect_valid_o = redir_valid_q;
    // eret returns to the EPC as CP0 presents it during REDIR
    assign redirect_pc_o    = redir_valid_q ? (eret_q ? epc_i : EXC_VECTOR) : 32'd0;

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - scoreboard bench for exc_commit
module tb_exc_commit;

    logic             clk;
    logic             resetn;
    logic [1:0]       valid_i;
    logic [1:0][4:0]  exc_code_i;
    logic [1:0]       has_exc_i;
    logic [1:0][31:0] pc_i;
    logic [1:0]       bd_i;
    logic [1:0][31:0] badvaddr_i;
    logic [1:0]       eret_i;
    logic [4:0]       trap_exc_code_i;
    logic [1:0]       trap_way_i;
    logic             int_pending_i;
    logic [31:0]      epc_i;
    logic [1:0]       commit_mask_o;
    logic             stall_o;
    logic             flush_o;
    logic             cp0_we_o;
    logic [4:0]       cp0_exc_code_o;
    logic [31:0]      cp0_epc_o;
    logic             cp0_bd_o;
    logic             cp0_badv_we_o;
    logic [31:0]      cp0_badvaddr_o;
    logic             cp0_eret_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;

`ifdef EXC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        badv_we;
        logic [31:0] badv;
        logic        eret;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    exc_commit dut (
        .clk              (clk),
        .resetn           (resetn),
        .valid_i          (valid_i),
        .exc_code_i       (exc_code_i),
        .has_exc_i        (has_exc_i),
        .pc_i             (pc_i),
        .bd_i             (bd_i),
        .badvaddr_i       (badvaddr_i),
        .eret_i           (eret_i),
        .trap_exc_code_i  (trap_exc_code_i),
        .trap_way_i       (trap_way_i),
        .int_pending_i    (int_pending_i),
        .epc_i            (epc_i),
        .commit_mask_o    (commit_mask_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .cp0_we_o         (cp0_we_o),
        .cp0_exc_code_o   (cp0_exc_code_o),
        .cp0_epc_o        (cp0_epc_o),
        .cp0_bd_o         (cp0_bd_o),
        .cp0_badv_we_o    (cp0_badv_we_o),
        .cp0_badvaddr_o   (cp0_badvaddr_o),
        .cp0_eret_o       (cp0_eret_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i         = '0;
        exc_code_i      = '0;
        has_exc_i       = '0;
        pc_i            = '0;
        bd_i            = '0;
        badvaddr_i      = '0;
        eret_i          = '0;
        trap_exc_code_i = '0;
        trap_way_i      = '0;
        int_pending_i   = 1'b0;
    endtask

    task automatic at_drive();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mask"},  32'(commit_mask_o), 32'd0);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_flush"}, 32'(flush_o), 32'd0);
        check({tag, "_we"},    32'(cp0_we_o), 32'd0);
        check({tag, "_epc"},   cp0_epc_o, 32'd0);
        check({tag, "_eret"},  32'(cp0_eret_o), 32'd0);
        check({tag, "_rv"},    32'(redirect_valid_o), 32'd0);
        check({tag, "_rpc"},   redirect_pc_o, 32'd0);
    endtask

    // Reference model: pick the event from the driven inputs and push the expected result
    task automatic predict(output bit evt, output logic [1:0] mask);
        bit       ev[2];
        logic [4:0] code[2];
        bit       er[2];
        int       w;
        exp_t     e;
        for (int k = 0; k < 2; k++) begin
            bit tr;
            tr = TRAP_EN && trap_way_i[k] && (trap_exc_code_i == 5'd13);
            ev[k] = 1'b0; code[k] = 5'd0; er[k] = 1'b0;
            if (k == 0 && int_pending_i && valid_i[0]) begin
                ev[k] = 1'b1;
            end else if (valid_i[k] && has_exc_i[k]) begin
                ev[k] = 1'b1; code[k] = exc_code_i[k];
            end else if (valid_i[k] && tr) begin
                ev[k] = 1'b1; code[k] = 5'd13;
            end else if (valid_i[k] && eret_i[k]) begin
                ev[k] = 1'b1; er[k] = 1'b1;
            end
        end
        evt  = ev[0] || ev[1];
        w    = ev[0] ? 0 : 1;
        mask = !evt ? valid_i : (w == 0 ? 2'b00 : (valid_i & 2'b01));
        if (evt) begin
            e.eret    = er[w];
            e.code    = er[w] ? 5'd0 : code[w];
            e.bd      = er[w] ? 1'b0 : bd_i[w];
            e.epc     = er[w] ? 32'd0 : (bd_i[w] ? pc_i[w] - 32'd4 : pc_i[w]);
            e.badv_we = !er[w] && (code[w] == 5'd4 || code[w] == 5'd5);
            e.badv    = e.badv_we ? badvaddr_i[w] : 32'd0;
            e.rpc     = er[w] ? epc_i : 32'hBFC0_0380;
            exp_q.push_back(e);
        end
    endtask

    // Drive one commit cycle (inputs already set) and follow the event sequence
    task automatic run_txn(input string tag);
        bit         evt;
        logic [1:0] mask;
        bit         done;
        exp_t       e;
        predict(evt, mask);
        @(negedge clk);
        check({tag, "_mask"},  32'(commit_mask_o), 32'(mask));
        check({tag, "_stall0"}, 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        if (!evt) begin
            idle_inputs();
            @(negedge clk);
            check({tag, "_noflush"}, 32'(flush_o), 32'd0);
            check({tag, "_nostall"}, 32'(stall_o), 32'd0);
            return;
        end
        // Noise while busy must be ignored
        valid_i   = 2'b11;
        has_exc_i = 2'b11;
        done = 1'b0;
        for (int i = 1; i <= 5 && !done; i++) begin
            @(negedge clk);
            if (i <= 3) check({tag, "_stall"}, 32'(stall_o), 32'd1);
            if (i == 1) check({tag, "_busymask"}, 32'(commit_mask_o), 32'd0);
            if (flush_o) check({tag, "_flush_lat"}, 32'(i), 32'd1);
            if (cp0_we_o || cp0_eret_o) begin
                e = exp_q[0];
                check({tag, "_cp0_lat"}, 32'(i), 32'd2);
                check({tag, "_we"},      32'(cp0_we_o), 32'(!e.eret));
                check({tag, "_eret"},    32'(cp0_eret_o), 32'(e.eret));
                check({tag, "_code"},    32'(cp0_exc_code_o), 32'(e.code));
                check({tag, "_epc"},     cp0_epc_o, e.epc);
                check({tag, "_bd"},      32'(cp0_bd_o), 32'(e.bd));
                check({tag, "_badv_we"}, 32'(cp0_badv_we_o), 32'(e.badv_we));
                check({tag, "_badv"},    cp0_badvaddr_o, e.badv);
            end
            if (redirect_valid_o) begin
                e = exp_q.pop_front();
                check({tag, "_redir_lat"}, 32'(i), 32'd3);
                check({tag, "_rpc"}, redirect_pc_o, e.rpc);
                done = 1'b1;
            end
        end
        if (!done) begin
            check({tag, "_redir_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        epc_i  = '0;
        resetn = 1'b0;
        #3;
        check_quiet("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Address error load on way0
        at_drive();
        valid_i = 2'b01; has_exc_i = 2'b01; exc_code_i[0] = 5'd4;
        pc_i[0] = 32'h8000_0100; badvaddr_i[0] = 32'h0000_1235;
        run_txn("adel_w0");

        // Way1 exception in a delay slot, way0 retires
        at_drive();
        valid_i = 2'b11; has_exc_i = 2'b10; exc_code_i[1] = 5'd10;
        bd_i = 2'b10; pc_i[1] = 32'h8000_0204; pc_i[0] = 32'h8000_0200;
        run_txn("bd_w1");

        // Trap on way1: event only with EXC_TRAP_EN
        at_drive();
        valid_i = 2'b11; trap_way_i = 2'b10; trap_exc_code_i = 5'd13;
        pc_i[1] = 32'h8000_0304;
        run_txn("trap_w1");

        // Interrupt beats eret on way0
        at_drive();
        valid_i = 2'b01; int_pending_i = 1'b1; eret_i = 2'b01; pc_i[0] = 32'h8000_0400;
        run_txn("int_eret");

        // eret returns to EPC
        at_drive();
        epc_i = 32'h8000_1000;
        valid_i = 2'b01; eret_i = 2'b01;
        run_txn("eret_w0");

        // Both ways faulting: way0 wins
        at_drive();
        valid_i = 2'b11; has_exc_i = 2'b11; exc_code_i[0] = 5'd12; exc_code_i[1] = 5'd4;
        pc_i[0] = 32'h8000_0500; pc_i[1] = 32'h8000_0504; badvaddr_i[1] = 32'hDEAD_0000;
        run_txn("both");

        // Delay-slot EPC wraps below zero
        at_drive();
        valid_i = 2'b01; has_exc_i = 2'b01; exc_code_i[0] = 5'd5; bd_i = 2'b01;
        pc_i[0] = 32'h0000_0000; badvaddr_i[0] = 32'h0000_0003;
        run_txn("wrap");

        // Clean pair, interrupt without way0, invalid faulting slot
        at_drive();
        valid_i = 2'b11;
        run_txn("clean");
        at_drive();
        valid_i = 2'b10; int_pending_i = 1'b1;
        run_txn("int_no_w0");
        at_drive();
        has_exc_i = 2'b01; eret_i = 2'b10;
        run_txn("invalid");

        // Random mix
        for (int n = 0; n < 30; n++) begin
            at_drive();
            valid_i         = 2'($urandom_range(0, 3));
            has_exc_i       = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            exc_code_i[0]   = 5'($urandom_range(0, 31));
            exc_code_i[1]   = 5'($urandom_range(0, 31));
            eret_i          = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            bd_i            = 2'($urandom_range(0, 3));
            pc_i[0]         = $urandom() & 32'hFFFF_FFFC;
            pc_i[1]         = pc_i[0] + 32'd4;
            badvaddr_i[0]   = $urandom();
            badvaddr_i[1]   = $urandom();
            int_pending_i   = ($urandom_range(0, 7) == 0);
            trap_way_i      = 2'($urandom_range(0, 2));
            trap_exc_code_i = ($urandom_range(0, 1) == 1) ? 5'd13 : 5'($urandom_range(0, 31));
            epc_i           = $urandom();
            run_txn("rand");
        end

        // Reset during CP0WR aborts the sequence
        at_drive();
        valid_i = 2'b01; has_exc_i = 2'b01; exc_code_i[0] = 5'd4;
        pc_i[0] = 32'h8000_0600; badvaddr_i[0] = 32'h0000_0777;
        @(posedge clk);
        #1;
        valid_i = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_we_before", 32'(cp0_we_o), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_quiet("rst_mid");
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_after_rv", 32'(redirect_valid_o), 32'd0);
            check("rst_after_we", 32'(cp0_we_o), 32'd0);
        end

        // First event after reset release
        at_drive();
        valid_i = 2'b01; has_exc_i = 2'b01; exc_code_i[0] = 5'd8; pc_i[0] = 32'h8000_0700;
        run_txn("post_rst");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
